// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle CPU (INIT, IF, ID, EX, MEM, WB)
// Inputs : clk, reset (async active-low), OpCode/Funct from IR, Zero from ALU
// Outputs: ALU control (ALUCtrl, Sign), datapath mux selects (ALUSrcA/B, ExtOp, PCSource,
//          IorD, RegDst, MemtoReg), write strobes (PCWrite, MemRead, MemWrite, IRWrite,
//          RegWrite) and per-instruction status pulses (Retired, Illegal)
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [4:0] ALUCtrl,
    output logic       Sign,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic       ExtOp,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       Retired,
    output logic       Illegal
);
    typedef enum logic [2:0] {S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
    localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010,
                           ALU_OR  = 5'b00011, ALU_XOR = 5'b00100, ALU_NOR = 5'b00101,
                           ALU_SLT = 5'b00110, ALU_SLL = 5'b10000, ALU_SRL = 5'b10001,
                           ALU_SRA = 5'b10010;
    state_t     r_state, w_state, w_next;
    logic       w_r, w_r_alu, w_r_shift, w_jr, w_iarith, w_lw, w_sw, w_beq, w_j, w_jal;
    logic       w_legal, w_unsigned, w_zext, w_mem, w_wb_path;
    logic [4:0] w_alu_op;
    // Spare encodings 6/7 behave exactly like INIT
    assign w_state    = (r_state > S_WB) ? S_INIT : r_state;
    assign w_r        = OpCode == 6'h00;
    assign w_r_alu    = w_r && (Funct[5:3] == 3'b100 || Funct == 6'h2A || Funct == 6'h2B);
    assign w_r_shift  = w_r && (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03);
    assign w_jr       = w_r && Funct == 6'h08;
    assign w_iarith   = OpCode >= 6'h08 && OpCode <= 6'h0D;
    assign w_lw       = OpCode == 6'h23;
    assign w_sw       = OpCode == 6'h2B;
    assign w_beq      = OpCode == 6'h04;
    assign w_j        = OpCode == 6'h02;
    assign w_jal      = OpCode == 6'h03;
    assign w_legal    = w_r_alu | w_r_shift | w_jr | w_iarith | w_lw | w_sw | w_beq | w_j | w_jal;
    assign w_unsigned = (w_r && (Funct == 6'h21 || Funct == 6'h23 || Funct == 6'h2B)) ||
                        OpCode == 6'h09 || OpCode == 6'h0B;
    assign w_zext     = OpCode == 6'h0C || OpCode == 6'h0D;
    assign w_mem      = w_lw | w_sw;
    assign w_wb_path  = w_r_alu | w_r_shift | w_iarith;
    // IF must not depend on the not-yet-loaded IR, so its Sign is fixed to the ADD default
    assign Sign = (w_state == S_IF) || (w_state != S_INIT && !w_unsigned);
    always_comb begin
        w_alu_op = ALU_ADD;
        if (w_r)
            case (Funct)
                6'h22, 6'h23: w_alu_op = ALU_SUB;
                6'h24:        w_alu_op = ALU_AND;
                6'h25:        w_alu_op = ALU_OR;
                6'h26:        w_alu_op = ALU_XOR;
                6'h27:        w_alu_op = ALU_NOR;
                6'h2A, 6'h2B: w_alu_op = ALU_SLT;
                6'h00:        w_alu_op = ALU_SLL;
                6'h02:        w_alu_op = ALU_SRL;
                6'h03:        w_alu_op = ALU_SRA;
                default:      w_alu_op = ALU_ADD;
            endcase
        else
            case (OpCode)
                6'h0A, 6'h0B: w_alu_op = ALU_SLT;
                6'h0C:        w_alu_op = ALU_AND;
                6'h0D:        w_alu_op = ALU_OR;
                6'h04:        w_alu_op = ALU_SUB;
                default:      w_alu_op = ALU_ADD;
            endcase
    end
    always_comb begin
        ALUCtrl  = ALU_ADD;
        ALUSrcA  = 2'd0;
        ALUSrcB  = 3'd0;
        ExtOp    = 1'b0;
        PCWrite  = 1'b0;
        PCSource = 2'd0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 2'd0;
        MemtoReg = 2'd0;
        Retired  = 1'b0;
        Illegal  = 1'b0;
        w_next   = S_IF;
        case (w_state)
            S_IF: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 3'd1;
                PCWrite = 1'b1;
                w_next  = S_ID;
            end
            S_ID: begin
                // Branch target PC+4+(imm<<2) is precomputed into ALUOut here
                ALUSrcB  = 3'd3;
                ExtOp    = 1'b1;
                PCWrite  = w_j | w_jal | w_jr;
                PCSource = w_jr ? 2'd3 : (w_j | w_jal) ? 2'd2 : 2'd0;
                Retired  = w_j | w_jal | w_jr;
                RegWrite = w_jal;
                RegDst   = w_jal ? 2'd2 : 2'd0;
                MemtoReg = w_jal ? 2'd2 : 2'd0;
                Illegal  = !w_legal;
                w_next   = (w_j | w_jal | w_jr | !w_legal) ? S_IF : S_EX;
            end
            S_EX: begin
                ALUCtrl  = w_alu_op;
                ALUSrcA  = w_r_shift ? 2'd2 : 2'd1;
                ALUSrcB  = w_r_shift ? 3'd4 : (w_iarith | w_mem) ? 3'd2 : 3'd0;
                ExtOp    = (w_iarith | w_mem) && !w_zext;
                PCSource = w_beq ? 2'd1 : 2'd0;
                PCWrite  = w_beq && Zero;
                Retired  = w_beq;
                w_next   = w_mem ? S_MEM : w_wb_path ? S_WB : S_IF;
            end
            S_MEM: begin
                MemRead  = w_lw;
                MemWrite = w_sw;
                IorD     = w_mem;
                Retired  = w_sw;
                w_next   = w_lw ? S_WB : S_IF;
            end
            S_WB: begin
                RegWrite = 1'b1;
                Retired  = 1'b1;
                RegDst   = w_r ? 2'd1 : 2'd0;
                MemtoReg = w_lw ? 2'd1 : 2'd0;
            end
            default: w_next = S_IF;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= S_INIT;
        else        r_state <= w_next;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle CPU datapath. It decodes OpCode/Funct from the instruction register and steps each instruction through fetch, decode, execute, memory and write-back. Per cycle it drives every datapath enable and mux select, plus the ALUCtrl/Sign pair consumed by the ALU. It is the producing end of the ALU control interface and consumes the ALU's zero flag for branches.

## Interface
- No parameters.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- OpCode  input  6  instr[31:26]; stable from the cycle after IF until next IF.
- Funct  input  6  instr[5:0]; same stability as OpCode.
- Zero  input  1  ALU zero flag, same cycle.
- ALUCtrl  output  5  ALU op: ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, NOR 00101, SLT 00110, SLL 10000, SRL 10001, SRA 10010.
- Sign  output  1  signed compare for SLT; 0 for addu/subu/sltu/sltiu.
- ALUSrcA  output  2  0=PC, 1=reg A (rs), 2=reg B (rt).
- ALUSrcB  output  3  0=reg B, 1=const 4, 2=ext imm, 3=ext imm<<2, 4=shamt zero-extended.
- ExtOp  output  1  1=sign-extend imm, 0=zero-extend.
- PCWrite  output  1  load PC this edge.
- PCSource  output  2  0=ALU result, 1=ALUOut reg, 2={PC[31:28],instr[25:0],00}, 3=reg A.
- IorD  output  1  memory address: 0=PC, 1=ALUOut.
- MemRead, MemWrite, IRWrite, RegWrite  output  1 each  strobes.
- RegDst  output  2  0=rt, 1=rd, 2=$31.
- MemtoReg  output  2  0=ALUOut, 1=MDR, 2=PC.
- Retired  output  1  one-cycle pulse on the last cycle of each legal instruction.
- Illegal  output  1  one-cycle pulse on unsupported encoding.

## Operation
- Supported R-type functs (OpCode 0): add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, sll 00, srl 02, sra 03, jr 08.
- Supported OpCodes: lw 23, sw 2B, beq 04, addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, j 02, jal 03.
- State register has 6 states: INIT, IF, ID, EX, MEM, WB.
- Outputs decode combinationally from state, OpCode, Funct and Zero. Any output not listed for a state is 0.
- INIT: all outputs 0. Next state is IF.
- IF: MemRead, IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=1, ADD, PCWrite, PCSource=0. Next state is ID.
- ID: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ADD (branch target into ALUOut). Exit depends on the instruction:
  - j: PCWrite, PCSource=2, Retired; next IF.
  - jal: as j, plus RegWrite, RegDst=2, MemtoReg=2 (PC already holds PC+4); next IF.
  - jr: PCWrite, PCSource=3, Retired; next IF.
  - Unsupported encoding: Illegal=1, no writes; next IF.
  - Otherwise next EX.
- EX:
  - R-type arith/logic: ALUSrcA=1, ALUSrcB=0; next WB.
  - Shifts: ALUSrcA=2, ALUSrcB=4; next WB.
  - I-type arith: ALUSrcA=1, ALUSrcB=2. ExtOp=0 for andi/ori, 1 otherwise. ALUCtrl ADD/SLT/AND/OR; next WB.
  - lw/sw: ADD, ALUSrcA=1, ALUSrcB=2, ExtOp=1; next MEM.
  - beq: SUB, ALUSrcA=1, ALUSrcB=0, PCSource=1, PCWrite=Zero, Retired; next IF.
- MEM:
  - lw: MemRead, IorD=1; next WB.
  - sw: MemWrite, IorD=1, Retired; next IF.
- WB: RegWrite, Retired; next IF.
  - R-type: RegDst=1, MemtoReg=0.
  - I-arith: RegDst=0, MemtoReg=0.
  - lw: RegDst=0, MemtoReg=1.
- Sign=1 except for addu, subu, addiu, sltu, sltiu. ALUCtrl during IF/ID/MEM/WB is ADD (00000) unless stated.
- Unreachable state encodings decode as INIT.

## Timing
- While reset=0: state is INIT and every output is 0, asynchronously.
- First rising edge after reset deasserts moves to IF.
- Reset asserted mid-instruction: immediate return to INIT, outputs 0. No partial write strobes may be emitted after reset asserts.
- CPI: j/jal/jr 2, beq 3, sw 4, R/I arith 4, lw 5, illegal 2.
- PCWrite in beq EX is combinational on Zero. Zero must settle within the same cycle.
- Retired and Illegal are never asserted in the same cycle.
- OpCode/Funct are ignored in INIT and IF (IR not yet loaded).

## Test plan
- Reset low for 3 cycles, then release. Required: all outputs 0 during reset; INIT → IF on first edge; IF drives MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=1.
- addu (Op 00, Funct 21). Required: EX shows ALUCtrl=00000, Sign=0, ALUSrcA=1, ALUSrcB=0; WB shows RegWrite=1, RegDst=1; Retired pulses in WB; next IF 4 cycles after the previous IF.
- lw (23) then sw (2B). Required: lw MEM shows MemRead=1, IorD=1, and WB shows MemtoReg=1, RegDst=0 (5 cycles); sw MEM shows MemWrite=1, then IF (4 cycles).
- beq (04) with Zero=1, then with Zero=0. Required: EX shows ALUCtrl=00001, PCSource=1; PCWrite=1 in the first case and 0 in the second; both return to IF.
- sll (00/00) then jal (03). Required: sll EX shows ALUCtrl=10000, ALUSrcA=2, ALUSrcB=4; jal ID shows PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2.
- OpCode 3F, then reset pulled low during the EX of an ori. Required: Illegal=1 for the single ID cycle with no strobes, then IF; on reset, outputs go to 0 immediately with RegWrite never asserted.
